// File: rtl/fifo_multi_line_buffer_if.sv
// Pixel-stream and column-tap bundle for fifo_multi_line_buffer.
// The slave modport is the buffer's view; the master modport is the pixel source/consumer's view.
interface fifo_multi_line_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LINE_WIDTH = 640,
    parameter int NUM_LINES  = 3,
    parameter int COL_W      = $clog2(LINE_WIDTH)
);
    logic                            valid_i;
    logic                            sof_i;
    logic [DATA_WIDTH-1:0]           data_i;
    logic [NUM_LINES*DATA_WIDTH-1:0] data_o;
    logic                            valid_o;
    logic [COL_W-1:0]                col_o;
    logic                            line_done_o;
    logic                            primed_o;

    modport slave (
        input  valid_i, sof_i, data_i,
        output data_o, valid_o, col_o, line_done_o, primed_o
    );

    modport master (
        output valid_i, sof_i, data_i,
        input  data_o, valid_o, col_o, line_done_o, primed_o
    );
endinterface

// File: rtl/fifo_multi_line_buffer.sv
// N-row line buffer: for each accepted pixel, emits the current pixel plus the same
// column from the previous NUM_LINES-1 lines, one cycle later.
module fifo_multi_line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int LINE_WIDTH = 640,
    parameter int NUM_LINES  = 3,
    parameter int COL_W      = $clog2(LINE_WIDTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    fifo_multi_line_buffer_if.slave   bus
);
    localparam int ROW_W = $clog2(NUM_LINES);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_LINES - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);

    logic [COL_W-1:0]                col_cnt_reg, col_cnt_next, col_addr;
    logic [ROW_W-1:0]                row_cnt_reg, row_cnt_next, row_eff;
    logic [DATA_WIDTH-1:0]           tap [NUM_LINES];
    logic [NUM_LINES*DATA_WIDTH-1:0] taps_packed;
    logic [NUM_LINES*DATA_WIDTH-1:0] data_reg;
    logic [COL_W-1:0]                col_reg;
    logic                            valid_reg;
    logic                            line_done_reg;
    logic                            primed_reg;
    logic                            sof_accept;
    logic                            at_last_row;

    // A start-of-frame pixel is treated as row 0 / column 0 regardless of the counters.
    always_comb begin
        sof_accept   = bus.valid_i & bus.sof_i;
        col_addr     = sof_accept ? '0 : col_cnt_reg;
        row_eff      = sof_accept ? '0 : row_cnt_reg;
        at_last_row  = (row_eff == ROW_LAST);
        col_cnt_next = col_addr + COL_W'(1);
        row_cnt_next = row_eff;
        if (col_addr == COL_LAST) begin
            col_cnt_next = '0;
            row_cnt_next = at_last_row ? row_eff : row_eff + ROW_W'(1);
        end
    end

    assign tap[0] = bus.data_i;

    // Each line memory reads its old word into the next tap and takes the newer
    // line's old word on the same edge, so the column shifts down by one line.
    generate
        for (genvar gi = 0; gi < NUM_LINES - 1; gi++) begin : g_line
            logic [DATA_WIDTH-1:0] mem_reg [LINE_WIDTH];

            assign tap[gi+1] = mem_reg[col_addr];

            always_ff @(posedge clk) begin
                if (bus.valid_i) begin
                    mem_reg[col_addr] <= tap[gi];
                end
            end
        end

        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_pack
            assign taps_packed[gi*DATA_WIDTH +: DATA_WIDTH] = tap[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt_reg   <= '0;
            row_cnt_reg   <= '0;
            data_reg      <= '0;
            col_reg       <= '0;
            valid_reg     <= 1'b0;
            line_done_reg <= 1'b0;
            primed_reg    <= 1'b0;
        end else begin
            valid_reg     <= bus.valid_i & at_last_row;
            line_done_reg <= bus.valid_i & at_last_row & (col_addr == COL_LAST);
            if (bus.valid_i) begin
                data_reg    <= taps_packed;
                col_reg     <= col_addr;
                col_cnt_reg <= col_cnt_next;
                row_cnt_reg <= row_cnt_next;
                primed_reg  <= (row_cnt_next == ROW_LAST);
            end
        end
    end

    assign bus.data_o      = data_reg;
    assign bus.valid_o     = valid_reg;
    assign bus.col_o       = col_reg;
    assign bus.line_done_o = line_done_reg;
    assign bus.primed_o    = primed_reg;

endmodule

// File: doc/fifo_multi_line_buffer.md
Name: fifo_multi_line_buffer

Overview:
- Parametrised N-row line buffer for sliding-window image kernels (Sobel, Gaussian, median).
- Accepts a raster pixel stream and emits, per accepted pixel, a vertical column of NUM_LINES taps: the current pixel plus the same column from the previous NUM_LINES-1 lines.
- Adds pixel width, line length and tap count as parameters, plus a valid qualifier, start-of-frame resync, priming detection and column/line-done status.
- Sits between the pixel source and the window/kernel register stage.

Parameters:
- DATA_WIDTH, 8, bits per pixel.
- LINE_WIDTH, 640, pixels per image line (>=2).
- NUM_LINES, 3, taps per output column (>=2); NUM_LINES-1 lines are stored.
- COL_W, $clog2(LINE_WIDTH), column counter width (derived; do not override).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid_i  input  1  data_i carries a pixel this cycle.
- sof_i  input  1  qualified by valid_i; this pixel is row 0, column 0 of a new frame.
- data_i  input  DATA_WIDTH  pixel in raster order.
- data_o  output  NUM_LINES*DATA_WIDTH  column taps; slice k (bits k*DATA_WIDTH +: DATA_WIDTH) is the pixel from k lines ago, so slice 0 is the newest.
- valid_o  output  1  data_o is a fully primed column.
- col_o  output  COL_W  column index of the pixel in slice 0 of data_o.
- line_done_o  output  1  one-cycle pulse with the output of column LINE_WIDTH-1.
- primed_o  output  1  level signal; NUM_LINES-1 full lines are stored since the last sof/reset.

Behaviour:
- Reset values (async assert, sync release):
  - data_o = 0, valid_o = 0, col_o = 0, line_done_o = 0, primed_o = 0.
  - Column counter = 0, row counter = 0.
  - Line storage contents are don't-care.
- Storage: NUM_LINES-1 line memories L1..L(NUM_LINES-1), each LINE_WIDTH deep, addressed by the column counter c.
- On an accepted pixel (valid_i = 1) at column c, in the same edge:
  - Read-before-write: tap0 = data_i; tapk = Lk[c] (old value) for k >= 1.
  - Write L1[c] <= data_i and Lk[c] <= L(k-1)[c] (old value).
  - Register the taps into data_o. Latency is exactly 1 cycle from input to data_o.
  - col_o <= c.
  - c wraps from LINE_WIDTH-1 to 0. The row counter increments on wrap and saturates at NUM_LINES-1.
- valid_o <= valid_i AND (row counter == NUM_LINES-1 at the time of acceptance).
  - The first valid_o therefore follows row NUM_LINES-1, column 0.
  - valid_o is low on cycles following valid_i = 0.
- primed_o = (row counter == NUM_LINES-1). It is registered and goes high on the edge that wraps line NUM_LINES-2.
- line_done_o <= valid_i AND (c == LINE_WIDTH-1) AND primed condition. It is aligned with valid_o.
- Stall (valid_i = 0): counters and memories hold; data_o and col_o hold their last values; valid_o and line_done_o are 0.
- sof_i with valid_i:
  - The pixel is treated as column 0 with the row counter forced to 0.
  - The pixel is still written to L1[0].
  - The c and row counters restart from that point (next c = 1).
  - valid_o for this pixel = 0 and primed_o drops on the same edge.
  - Stale memory contents are never presented with valid_o = 1, because priming must recur.
- sof_i without valid_i is ignored.
- sof_i mid-line: the partial line is abandoned with no error flag.
- Async rst mid-frame: all outputs drop immediately; the next frame must re-prime.
- Memory inference: a single-port read-first RAM or a register array per line is acceptable, provided the 1-cycle latency and read-before-write semantics hold.

Test Plan (DATA_WIDTH=8, LINE_WIDTH=4, NUM_LINES=3; stimulus pixel = row*16+col, continuous valid_i, sof_i on the first pixel):
- Priming: stream rows 0-1 -> valid_o stays 0. primed_o rises on the edge after input 0x13. The first valid_o comes one cycle after input 0x20, with data_o = {0x00,0x10,0x20}, col_o = 0.
- Steady state: input 0x21 -> next cycle data_o = {0x01,0x11,0x21}, col_o = 1. Input 0x23 -> line_done_o = 1 with data_o = {0x03,0x13,0x23}. Row 3 column 2 gives {0x12,0x22,0x32}.
- Stalls: insert valid_i = 0 gaps of 1 and 3 cycles between pixels of row 2 -> valid_o = 0 during gaps, data_o holds, and resulting columns are identical to the no-gap run.
- Resync: assert sof_i with pixel 0x99 at row 3 column 1 -> valid_o = 0 and primed_o = 0 on the next edge. Two more full lines are needed before valid_o reasserts. The first new column contains 0x99 as the oldest tap (slice 2).
- Async reset: assert rst between clock edges during row 2 -> all outputs are 0 before the next edge. After release, streaming restarts and priming is repeated.
- Parameter sweep: NUM_LINES=5, LINE_WIDTH=7, DATA_WIDTH=10, random stream checked against a software reference model -> every valid_o column matches, and the count of valid_o equals (rows-4)*7 per frame.
